// File: rtl/sram_stream_ctrl.sv
// Streams len words between a valid/ready port and a 1-cycle-read single-port SRAM (LOAD writes, DUMP reads).
// LOAD writes combinationally on handshake; DUMP data appears 2 cycles after the read issue and a 3-entry FIFO absorbs i_out_ready stalls.
module sram_stream_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [WIDTH-1:0]      i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_ce_N,
  output logic                  o_rdWr_N,
  output logic [ADDR_WIDTH-1:0] o_ramAddr,
  output logic [WIDTH-1:0]      o_ramData,
  input  logic [WIDTH-1:0]      i_ramData
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DONE} state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]     pop_cnt_q, pop_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [WIDTH-1:0]        fifo_q [3];
  logic [WIDTH-1:0]        fifo_d [3];
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;

  logic                    load_hs, rd_issue, push, pop;
  logic [1:0]              occ;
  logic [ADDR_WIDTH-1:0]   acc_addr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pop_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      rd_pend_q  <= rd_pend_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Pending read counts against FIFO space so its data always has a slot when it lands.
  always_comb begin
    occ      = fifo_cnt_q + {1'b0, rd_pend_q};
    acc_addr = base_q + cnt_q[ADDR_WIDTH-1:0];
    load_hs  = (state_q == S_LOAD) && i_in_valid && !i_rst;
    rd_issue = (state_q == S_DUMP) && !i_rst && (cnt_q != len_q) && (occ < 2'd3);
    push     = rd_pend_q;
    pop      = (fifo_cnt_q != 2'd0) && i_out_ready;
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pop_cnt_d = pop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d    = i_base_addr;
          len_d     = i_len;
          cnt_d     = '0;
          pop_cnt_d = '0;
          if (i_len == '0)  state_d = S_DONE;
          else if (i_mode)  state_d = S_DUMP;
          else              state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == len_q) state_d = S_DONE;
        end
      end
      S_DUMP: begin
        if (rd_issue) cnt_d = cnt_q + CNT_ONE;
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CNT_ONE;
          if (pop_cnt_d == len_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    rd_pend_d  = rd_issue;
    if (push) begin
      fifo_d[wr_ptr_q] = i_ramData;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    o_busy      = (state_q == S_LOAD) || (state_q == S_DUMP);
    o_done      = (state_q == S_DONE);
    o_in_ready  = (state_q == S_LOAD);
    o_out_valid = (fifo_cnt_q != 2'd0);
    o_out_data  = fifo_q[rd_ptr_q];
    o_ce_N      = !(load_hs || rd_issue);
    o_rdWr_N    = !load_hs;
    o_ramAddr   = (load_hs || rd_issue) ? acc_addr : '0;
    o_ramData   = load_hs ? i_in_data : '0;
  end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl with a behavioural SRAM and queue-based scoreboards.
module tb_sram_stream_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_mode = 1'b0;
  logic [3:0]  i_base_addr = '0;
  logic [4:0]  i_len = '0;
  logic        o_busy, o_done;
  logic [15:0] i_in_data = '0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] o_out_data;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic        o_ce_N, o_rdWr_N;
  logic [3:0]  o_ramAddr;
  logic [15:0] o_ramData;
  wire  [15:0] ram_rdata;

  typedef struct packed { logic [3:0] a; logic [15:0] d; } wr_t;
  wr_t         wr_q [$];
  logic [3:0]  rd_q [$];
  logic [15:0] out_q [$];
  logic [15:0] ref_mem [16];

  int n_tests = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;

  logic [15:0] sram [16];
  logic [15:0] sram_rd_dat = '0;
  logic        sram_rd_en = 1'b0;

  always #5 clk = ~clk;

  sram_stream_ctrl #(.WIDTH(16), .ADDR_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_base_addr(i_base_addr), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_ce_N(o_ce_N), .o_rdWr_N(o_rdWr_N), .o_ramAddr(o_ramAddr), .o_ramData(o_ramData),
    .i_ramData(ram_rdata)
  );

  // SRAM: registered read, output floats when no read was issued last cycle.
  always @(posedge clk) begin
    sram_rd_en <= 1'b0;
    if (!o_ce_N) begin
      if (!o_rdWr_N) sram[o_ramAddr] <= o_ramData;
      else begin
        sram_rd_dat <= sram[o_ramAddr];
        sram_rd_en  <= 1'b1;
      end
    end
  end
  assign ram_rdata = sram_rd_en ? sram_rd_dat : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Bus monitor: every SRAM access and every output pop is matched against the scoreboards.
  always @(negedge clk) begin
    if (i_rst) begin
      rd_cnt  = 0;
      pop_cnt = 0;
    end else begin
      if (!o_ce_N && !o_rdWr_N) begin
        wr_t e;
        wr_seen++;
        check("wr_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("wr_addr", {28'd0, o_ramAddr}, {28'd0, e.a});
          check("wr_data", {16'd0, o_ramData}, {16'd0, e.d});
        end
      end
      if (!o_ce_N && o_rdWr_N) begin
        rd_cnt++;
        check("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
        if (rd_q.size() != 0) check("rd_addr", {28'd0, o_ramAddr}, {28'd0, rd_q.pop_front()});
      end
      if (o_out_valid && i_out_ready) begin
        pop_cnt++;
        check("out_known", {31'd0, $isunknown(o_out_data)}, 32'd0);
        check("out_expected", {31'd0, out_q.size() != 0}, 32'd1);
        if (out_q.size() != 0) check("out_data", {16'd0, o_out_data}, {16'd0, out_q.pop_front()});
      end
      if (!o_ce_N && o_rdWr_N) check("reads_ahead", {31'd0, (rd_cnt - pop_cnt) <= 3}, 32'd1);
    end
  end

  task automatic do_load(input logic [3:0] base, input logic [4:0] len, input logic [15:0] seed);
    logic [3:0]  a;
    logic [15:0] d;
    i_start = 1'b1; i_mode = 1'b0; i_base_addr = base; i_len = len;
    samp();
    step();
    i_start = 1'b0;
    for (int k = 0; k < int'(len); k++) begin
      a = base + 4'(k);
      d = seed + 16'(k);
      i_in_valid = 1'b1; i_in_data = d;
      wr_q.push_back({a, d});
      ref_mem[a] = d;
      samp();
      check("load_ready", {31'd0, o_in_ready}, 32'd1);
      step();
    end
    i_in_valid = 1'b0;
    samp();
    check("load_done", {31'd0, o_done}, 32'd1);
    step();
    check("load_wr_q_empty", wr_q.size(), 32'd0);
  endtask

  task automatic do_dump(input logic [3:0] base, input logic [4:0] len, input int kind);
    bit          got_done = 0;
    bit          stall = 0;
    logic [15:0] held = '0;
    for (int i = 0; i < int'(len); i++) begin
      rd_q.push_back(base + 4'(i));
      out_q.push_back(ref_mem[base + 4'(i)]);
    end
    i_start = 1'b1; i_mode = 1'b1; i_base_addr = base; i_len = len; i_out_ready = 1'b1;
    samp();
    step();
    i_start = 1'b0;
    for (int c = 0; c < 4 * int'(len) + 20 && !got_done; c++) begin
      case (kind)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      samp();
      if (stall) check("stall_hold", {16'd0, o_out_data}, {16'd0, held});
      stall = o_out_valid && !i_out_ready;
      held  = o_out_data;
      if (o_done) got_done = 1;
      step();
    end
    i_out_ready = 1'b0;
    check("dump_done", {31'd0, got_done}, 32'd1);
    check("dump_out_q_empty", out_q.size(), 32'd0);
    check("dump_rd_q_empty", rd_q.size(), 32'd0);
  endtask

  initial begin
    // reset then idle
    step();
    step();
    i_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      samp();
      check("idle_ce_n", {31'd0, o_ce_N}, 32'd1);
      check("idle_busy", {31'd0, o_busy}, 32'd0);
      check("idle_done", {31'd0, o_done}, 32'd0);
      check("idle_out_valid", {31'd0, o_out_valid}, 32'd0);
      check("idle_in_ready", {31'd0, o_in_ready}, 32'd0);
      step();
    end
    check("idle_no_writes", wr_seen, 32'd0);

    // LOAD base=3 len=4, start re-asserted mid-command must be ignored
    i_start = 1'b1; i_mode = 1'b0; i_base_addr = 4'd3; i_len = 5'd4;
    samp();
    check("load_start_busy", {31'd0, o_busy}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      i_in_valid = 1'b1;
      i_in_data  = 16'hA001 + 16'(k);
      wr_q.push_back({4'd3 + 4'(k), i_in_data});
      ref_mem[4'd3 + 4'(k)] = i_in_data;
      if (k == 1) begin
        i_start = 1'b1; i_mode = 1'b1; i_base_addr = 4'd0; i_len = 5'd1;
      end else i_start = 1'b0;
      samp();
      check("load_busy", {31'd0, o_busy}, 32'd1);
      check("load_ce_n", {31'd0, o_ce_N}, 32'd0);
      step();
    end
    i_start = 1'b0;
    i_in_data = 16'hA005;
    samp();
    check("load_done_pulse", {31'd0, o_done}, 32'd1);
    check("load_done_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("load_done_ce_n", {31'd0, o_ce_N}, 32'd1);
    step();
    i_in_valid = 1'b0;
    samp();
    check("load_done_once", {31'd0, o_done}, 32'd0);
    check("load_wr_q", wr_q.size(), 32'd0);
    step();

    // DUMP base=3 len=4 with ready high: exact latency and throughput
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(4'd3 + 4'(i));
      out_q.push_back(ref_mem[4'd3 + 4'(i)]);
    end
    i_start = 1'b1; i_mode = 1'b1; i_base_addr = 4'd3; i_len = 5'd4; i_out_ready = 1'b1;
    samp();
    step();
    i_start = 1'b0;
    samp();
    check("dump_first_read", {31'd0, o_ce_N}, 32'd0);
    check("dump_rdwr", {31'd0, o_rdWr_N}, 32'd1);
    check("dump_lat1_valid", {31'd0, o_out_valid}, 32'd0);
    step();
    samp();
    check("dump_lat2_valid", {31'd0, o_out_valid}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      samp();
      check("dump_valid", {31'd0, o_out_valid}, 32'd1);
      check("dump_no_extra_read", {31'd0, o_ce_N}, (k < 2) ? 32'd0 : 32'd1);
      step();
    end
    samp();
    check("dump_done_pulse", {31'd0, o_done}, 32'd1);
    check("dump_done_valid", {31'd0, o_out_valid}, 32'd0);
    step();
    check("dump_out_q", out_q.size(), 32'd0);
    i_out_ready = 1'b0;

    // wrap-around addresses with stalling consumer
    do_load(4'd14, 5'd4, 16'hB000);
    do_dump(4'd14, 5'd4, 1);

    // zero length in each mode; start during DONE ignored
    for (int m = 0; m < 2; m++) begin
      i_start = 1'b1; i_mode = 1'(m); i_base_addr = 4'd5; i_len = 5'd0;
      samp();
      step();
      i_len = 5'd4;
      samp();
      check("len0_done", {31'd0, o_done}, 32'd1);
      check("len0_busy", {31'd0, o_busy}, 32'd0);
      check("len0_ce_n", {31'd0, o_ce_N}, 32'd1);
      step();
      i_start = 1'b0;
      samp();
      check("len0_idle_busy", {31'd0, o_busy}, 32'd0);
      check("len0_idle_done", {31'd0, o_done}, 32'd0);
      step();
      samp();
      check("len0_start_ignored", {31'd0, o_busy}, 32'd0);
      step();
    end

    // reset mid-DUMP with two words queued and a read in flight
    rd_q.push_back(4'd3); rd_q.push_back(4'd4); rd_q.push_back(4'd5);
    i_start = 1'b1; i_mode = 1'b1; i_base_addr = 4'd3; i_len = 5'd4; i_out_ready = 1'b0;
    samp();
    step();
    i_start = 1'b0;
    samp(); step();
    samp(); step();
    samp();
    check("mid_valid", {31'd0, o_out_valid}, 32'd1);
    step();
    i_rst = 1'b1;
    samp();
    check("rst_cycle_ce_n", {31'd0, o_ce_N}, 32'd1);
    step();
    i_rst = 1'b0;
    samp();
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_ce_n", {31'd0, o_ce_N}, 32'd1);
    check("rst_rdwr_n", {31'd0, o_rdWr_N}, 32'd1);
    check("rst_addr", {28'd0, o_ramAddr}, 32'd0);
    check("rst_wdata", {16'd0, o_ramData}, 32'd0);
    check("rst_rd_q", rd_q.size(), 32'd0);
    step();
    do_load(4'd0, 5'd2, 16'hC000);
    do_dump(4'd0, 5'd2, 0);

    // full-depth transfer from a mid-array base, random backpressure
    do_load(4'd9, 5'd16, 16'hD000);
    do_dump(4'd9, 5'd16, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
